// File: rtl/clock_time_setter.sv
// clock_time_setter
//   Time-keeping and user-setting stage of the digital clock. Keeps HH:MM:SS in
//   BCD, derives a 1 Hz tick, debounces the two push buttons and runs the
//   RUN / SET_HOURS / SET_MINUTES mode FSM with blinking of the selected digits.
//
// Ports
//   sys_clk      in   system clock (27 MHz)
//   sys_rst      in   asynchronous active-high reset
//   btn_mode_n   in   raw mode button, active-low, asynchronous
//   btn_inc_n    in   raw increment button, active-low, asynchronous
//   hours_1/0    out  hours tens (0-2) / units (0-9), BCD
//   minutes_1/0  out  minutes tens (0-5) / units (0-9), BCD
//   seconds_1/0  out  seconds tens (0-5) / units (0-9), BCD
//   digit_blank  out  1 = digit off; [3]=hours_1 [2]=hours_0 [1]=minutes_1 [0]=minutes_0
//   mode         out  00 RUN, 01 SET_HOURS, 10 SET_MINUTES
//   tick_1hz     out  one-cycle pulse per second (RUN only)
module clock_time_setter #(
    parameter int unsigned TICK_DIV        = 27000000,
    parameter int unsigned DEBOUNCE_CYCLES = 540000,
    parameter int unsigned BLINK_DIV       = 6750000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    output logic [1:0] hours_1,
    output logic [3:0] hours_0,
    output logic [2:0] minutes_1,
    output logic [3:0] minutes_0,
    output logic [2:0] seconds_1,
    output logic [3:0] seconds_0,
    output logic [3:0] digit_blank,
    output logic [1:0] mode,
    output logic       tick_1hz
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        StRun        = 2'b00,
        StSetHours   = 2'b01,
        StSetMinutes = 2'b10
    } mode_e;

    // Button vectors: index 0 = mode button, index 1 = increment button.
    // Levels are kept raw (1 = released).
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    acc_q, acc_d;
    logic [1:0]    press_q, press_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    mode_e         mode_q, mode_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    blank_q, blank_d;

    logic [1:0] h1_q, h1_d;
    logic [3:0] h0_q, h0_d;
    logic [2:0] m1_q, m1_d;
    logic [3:0] m0_q, m0_d;
    logic [2:0] s1_q, s1_d;
    logic [3:0] s0_q, s0_d;

    logic       mode_press, inc_press, run_free, tick_wrap, blink_wrap;
    logic [1:0] h1_inc;
    logic [3:0] h0_inc;
    logic [2:0] m1_inc, s1_inc;
    logic [3:0] m0_inc, s0_inc;
    logic       m_wrap, s_wrap;

    // Debounce: count consecutive cycles where the synchronized level differs
    // from the accepted one; accept on the last count, pulse only on a press.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            acc_d[i]    = acc_q[i];
            press_d[i]  = 1'b0;
            db_cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    acc_d[i]   = sync2_q[i];
                    press_d[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Mode press beats a coincident increment press.
    assign mode_press = press_q[0];
    assign inc_press  = press_q[1] & ~press_q[0];

    // BCD increment candidates
    always_comb begin
        h1_inc = h1_q;
        h0_inc = h0_q + 4'd1;
        if (h1_q == 2'd2 && h0_q == 4'd3) begin
            h1_inc = 2'd0;
            h0_inc = 4'd0;
        end else if (h0_q == 4'd9) begin
            h1_inc = h1_q + 2'd1;
            h0_inc = 4'd0;
        end

        m_wrap = (m1_q == 3'd5) && (m0_q == 4'd9);
        m1_inc = m1_q;
        m0_inc = m0_q + 4'd1;
        if (m0_q == 4'd9) begin
            m0_inc = 4'd0;
            m1_inc = m_wrap ? 3'd0 : m1_q + 3'd1;
        end

        s_wrap = (s1_q == 3'd5) && (s0_q == 4'd9);
        s1_inc = s1_q;
        s0_inc = s0_q + 4'd1;
        if (s0_q == 4'd9) begin
            s0_inc = 4'd0;
            s1_inc = s_wrap ? 3'd0 : s1_q + 3'd1;
        end
    end

    always_comb begin
        // Mode FSM
        mode_d = mode_q;
        if (mode_press) begin
            unique case (mode_q)
                StRun:        mode_d = StSetHours;
                StSetHours:   mode_d = StSetMinutes;
                StSetMinutes: mode_d = StRun;
                default:      mode_d = StRun;
            endcase
        end

        // Tick counter is held at 0 outside RUN, including the cycle RUN is left,
        // so re-entering RUN restarts a full second.
        run_free   = (mode_q == StRun) && !mode_press;
        tick_wrap  = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = (run_free && !tick_wrap) ? tick_cnt_q + 1'b1 : '0;
        tick_d     = run_free && tick_wrap;

        // Time registers
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        s1_d = s1_q;
        s0_d = s0_q;
        if (mode_q == StRun && tick_q) begin
            s1_d = s1_inc;
            s0_d = s0_inc;
            if (s_wrap) begin
                m1_d = m1_inc;
                m0_d = m0_inc;
                if (m_wrap) begin
                    h1_d = h1_inc;
                    h0_d = h0_inc;
                end
            end
        end else if (mode_q == StSetHours && inc_press) begin
            h1_d = h1_inc;
            h0_d = h0_inc;
        end else if (mode_q == StSetMinutes) begin
            if (mode_press) begin
                s1_d = 3'd0;
                s0_d = 4'd0;
            end else if (inc_press) begin
                m1_d = m1_inc;
                m0_d = m0_inc;
            end
        end

        // Blink restarts on every mode change so the selected digits show at once.
        blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV - 1));
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        phase_d     = blink_wrap ? ~phase_q : phase_q;
        if (mode_press) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end

        unique case (mode_d)
            StSetHours:   blank_d = {phase_d, phase_d, 2'b00};
            StSetMinutes: blank_d = {2'b00, phase_d, phase_d};
            default:      blank_d = 4'b0000;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            acc_q       <= 2'b11;
            press_q     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
            mode_q      <= StRun;
            tick_cnt_q  <= '0;
            tick_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blank_q     <= 4'b0000;
            h1_q        <= '0;
            h0_q        <= '0;
            m1_q        <= '0;
            m0_q        <= '0;
            s1_q        <= '0;
            s0_q        <= '0;
        end else begin
            sync1_q     <= {btn_inc_n, btn_mode_n};
            sync2_q     <= sync1_q;
            acc_q       <= acc_d;
            press_q     <= press_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            mode_q      <= mode_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_q      <= tick_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blank_q     <= blank_d;
            h1_q        <= h1_d;
            h0_q        <= h0_d;
            m1_q        <= m1_d;
            m0_q        <= m0_d;
            s1_q        <= s1_d;
            s0_q        <= s0_d;
        end
    end

    assign hours_1     = h1_q;
    assign hours_0     = h0_q;
    assign minutes_1   = m1_q;
    assign minutes_0   = m0_q;
    assign seconds_1   = s1_q;
    assign seconds_0   = s0_q;
    assign digit_blank = blank_q;
    assign mode        = mode_q;
    assign tick_1hz    = tick_q;

endmodule
